// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and FSM state types for the memory-backed slave responder.
package axi_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam int unsigned AXI_4K_BYTES = 4096;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_FETCH,
    R_DATA
  } rd_state_t;

endpackage

// File: rtl/axi_slv_req_chk.sv
// Combinational legality check of an AXI address request (AW or AR).
// DECERR when any beat falls outside the RAM; otherwise SLVERR for a
// misaligned start, wrong size, WRAP/reserved burst or an INCR burst that
// crosses a 4 KB page; otherwise OKAY.
module axi_slv_req_chk
  import axi_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    MEM_DEPTH  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            len,
  input  logic [2:0]            size,
  input  logic [1:0]            burst,
  output logic [1:0]            resp
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int LSB   = $clog2(BYTES);
  localparam int IW    = ADDR_WIDTH + 1;

  logic [IW-1:0] first_idx;
  logic [IW-1:0] last_idx;
  logic [13:0]   end_byte;
  logic          out_of_range;
  logic          protocol_err;

  // Classify the request; one extra index bit keeps start+len from wrapping.
  // NOTE: every signal assigned here gets a value on every path, so no latch can be inferred.
  always_comb begin
    first_idx    = {1'b0, addr - BASE_ADDR} >> LSB;
    last_idx     = first_idx + ((burst == AXI_BURST_INCR) ? IW'(len) : '0);
    out_of_range = (addr < BASE_ADDR) || (last_idx >= IW'(MEM_DEPTH));
    end_byte     = 14'(addr[11:0]) + (14'(len) + 14'd1) * 14'(BYTES);
    protocol_err = (addr[LSB-1:0] != '0)
                || (size != 3'(LSB))
                || burst[1]
                || ((burst == AXI_BURST_INCR) && (end_byte > 14'(AXI_4K_BYTES)));
    if (out_of_range)      resp = AXI_RESP_DECERR;
    else if (protocol_err) resp = AXI_RESP_SLVERR;
    else                   resp = AXI_RESP_OKAY;
  end

endmodule

// File: rtl/axi_slave_mem_responder.sv
// AXI4 slave responder backed by a word-addressed RAM. Independent write
// (W_IDLE->W_DATA->W_RESP) and read (R_IDLE->R_FETCH->R_DATA) FSMs service
// one burst each concurrently. Illegal requests are answered with the latched
// SLVERR/DECERR and never touch the RAM.
// Optional: define AXI_SLV_STALL_EN for LFSR-driven random backpressure on
// awready, wready and arready.
module axi_slave_mem_responder
  import axi_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    MEM_DEPTH  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(MEM_DEPTH);

  // NOTE: the RAM array is deliberately left out of reset; contents survive rst.
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic                  stall;

  wr_state_t  w_state, w_next;
  logic [IDX_W-1:0] w_idx;
  logic [7:0] w_len, w_beat;
  logic [1:0] w_burst, w_resp, aw_resp;
  logic       w_fire, w_mismatch, aw_hs, w_hs;

  rd_state_t  r_state, r_next;
  logic [IDX_W-1:0] r_idx;
  logic [7:0] r_len, r_beat;
  logic [1:0] r_burst, r_resp, ar_resp;
  logic       r_last_beat, ar_hs, r_hs;

  axi_slv_req_chk #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
                    .MEM_DEPTH(MEM_DEPTH), .BASE_ADDR(BASE_ADDR)) u_aw_chk (
    .addr(s_axi_awaddr), .len(s_axi_awlen), .size(s_axi_awsize),
    .burst(s_axi_awburst), .resp(aw_resp)
  );

  axi_slv_req_chk #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
                    .MEM_DEPTH(MEM_DEPTH), .BASE_ADDR(BASE_ADDR)) u_ar_chk (
    .addr(s_axi_araddr), .len(s_axi_arlen), .size(s_axi_arsize),
    .burst(s_axi_arburst), .resp(ar_resp)
  );

`ifdef AXI_SLV_STALL_EN
  logic [7:0] lfsr;

  // Free-running x^8+x^6+x^5+x^4+1 LFSR; stalls the readies one cycle in four on average.
  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) lfsr <= 8'hA5;
    else     lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign stall = (lfsr[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  assign aw_hs       = s_axi_awvalid && s_axi_awready;
  assign w_hs        = s_axi_wvalid && s_axi_wready;
  assign ar_hs       = s_axi_arvalid && s_axi_arready;
  assign r_hs        = s_axi_rvalid && s_axi_rready;
  assign r_last_beat = (r_beat == r_len);

  // Write FSM state register.
  always_ff @(posedge clk) begin
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_next;
  end

  // Write FSM next state and channel outputs; a wlast/len disagreement ends the burst.
  always_comb begin
    w_next        = w_state;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    s_axi_bresp   = AXI_RESP_OKAY;
    w_mismatch    = 1'b0;
    w_fire        = 1'b0;
    unique case (w_state)
      W_IDLE: begin
        s_axi_awready = !stall;
        if (s_axi_awvalid && !stall) w_next = W_DATA;
      end
      W_DATA: begin
        s_axi_wready = !stall;
        if (s_axi_wvalid && !stall) begin
          w_mismatch = (s_axi_wlast != (w_beat == w_len));
          w_fire     = !w_mismatch && (w_resp == AXI_RESP_OKAY);
          if (s_axi_wlast || (w_beat == w_len)) w_next = W_RESP;
        end
      end
      W_RESP: begin
        s_axi_bvalid = 1'b1;
        s_axi_bresp  = w_resp;
        if (s_axi_bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  // Write burst bookkeeping: latch the request, then step beat and word index.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_idx   <= '0;
      w_len   <= '0;
      w_beat  <= '0;
      w_burst <= AXI_BURST_INCR;
      w_resp  <= AXI_RESP_OKAY;
    end else if (aw_hs) begin
      w_idx   <= IDX_W'((s_axi_awaddr - BASE_ADDR) >> LSB);
      w_len   <= s_axi_awlen;
      w_beat  <= '0;
      w_burst <= s_axi_awburst;
      w_resp  <= aw_resp;
    end else if (w_hs) begin
      if (w_mismatch && (w_resp != AXI_RESP_DECERR)) w_resp <= AXI_RESP_SLVERR;
      w_beat <= w_beat + 8'd1;
      if (w_burst == AXI_BURST_INCR) w_idx <= w_idx + IDX_W'(1);
    end
  end

  // Byte-enabled RAM write for accepted beats of a legal burst.
  always_ff @(posedge clk) begin
    if (w_fire) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s_axi_wstrb[b]) mem[w_idx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
      end
    end
  end

  // Read FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_next;
  end

  // Read FSM next state and channel outputs; every beat is preceded by one fetch cycle.
  always_comb begin
    r_next        = r_state;
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    s_axi_rlast   = 1'b0;
    s_axi_rresp   = AXI_RESP_OKAY;
    unique case (r_state)
      R_IDLE: begin
        s_axi_arready = !stall;
        if (s_axi_arvalid && !stall) r_next = R_FETCH;
      end
      R_FETCH: r_next = R_DATA;
      R_DATA: begin
        s_axi_rvalid = 1'b1;
        s_axi_rresp  = r_resp;
        s_axi_rlast  = r_last_beat;
        if (s_axi_rready) r_next = r_last_beat ? R_IDLE : R_FETCH;
      end
      default: r_next = R_IDLE;
    endcase
  end

  // Read burst bookkeeping: latch the request, then step after each accepted beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx   <= '0;
      r_len   <= '0;
      r_beat  <= '0;
      r_burst <= AXI_BURST_INCR;
      r_resp  <= AXI_RESP_OKAY;
    end else if (ar_hs) begin
      r_idx   <= IDX_W'((s_axi_araddr - BASE_ADDR) >> LSB);
      r_len   <= s_axi_arlen;
      r_beat  <= '0;
      r_burst <= s_axi_arburst;
      r_resp  <= ar_resp;
    end else if (r_hs && !r_last_beat) begin
      r_beat <= r_beat + 8'd1;
      if (r_burst == AXI_BURST_INCR) r_idx <= r_idx + IDX_W'(1);
    end
  end

  // Registered RAM read in R_FETCH; a same-cycle write lands after this sample (old data).
  always_ff @(posedge clk) begin
    if (rst)                    s_axi_rdata <= '0;
    else if (r_state == R_FETCH) s_axi_rdata <= (r_resp == AXI_RESP_OKAY) ? mem[r_idx] : '0;
  end

endmodule

// File: tb/tb_axi_slave_mem_responder.sv
// Directed self-checking bench for axi_slave_mem_responder (default build,
// 32-bit data, 1024-word RAM at address 0). Inputs change and outputs are
// sampled on the falling clock edge.
`timescale 1ns/1ps
module tb_axi_slave_mem_responder;

  localparam int LIM = 64;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;
  localparam logic [1:0] FIXED  = 2'b00;
  localparam logic [1:0] INCR   = 2'b01;
  localparam logic [1:0] WRAP   = 2'b10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_axi_awaddr = '0;
  logic [7:0]  s_axi_awlen = '0;
  logic [2:0]  s_axi_awsize = '0;
  logic [1:0]  s_axi_awburst = '0;
  logic        s_axi_awvalid = 1'b0;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0]  s_axi_wstrb = '0;
  logic        s_axi_wlast = 1'b0;
  logic        s_axi_wvalid = 1'b0;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready = 1'b0;
  logic [31:0] s_axi_araddr = '0;
  logic [7:0]  s_axi_arlen = '0;
  logic [2:0]  s_axi_arsize = '0;
  logic [1:0]  s_axi_arburst = '0;
  logic        s_axi_arvalid = 1'b0;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rlast;
  logic        s_axi_rvalid;
  logic        s_axi_rready = 1'b0;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  axi_slave_mem_responder dut (
    .clk(clk), .rst(rst),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen), .s_axi_awsize(s_axi_awsize),
    .s_axi_awburst(s_axi_awburst), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize),
    .s_axi_arburst(s_axi_arburst), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic send_aw(input logic [31:0] a, input logic [7:0] len,
                         input logic [1:0] burst, input logic [2:0] size);
    int n = 0;
    s_axi_awaddr = a; s_axi_awlen = len; s_axi_awburst = burst; s_axi_awsize = size;
    s_axi_awvalid = 1'b1;
    while (s_axi_awready !== 1'b1 && n < LIM) begin @(negedge clk); n++; end
    check("aw_accept", 64'(n < LIM), 64'd1);
    @(negedge clk);
    s_axi_awvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] a, input logic [7:0] len,
                         input logic [1:0] burst, input logic [2:0] size);
    int n = 0;
    s_axi_araddr = a; s_axi_arlen = len; s_axi_arburst = burst; s_axi_arsize = size;
    s_axi_arvalid = 1'b1;
    while (s_axi_arready !== 1'b1 && n < LIM) begin @(negedge clk); n++; end
    check("ar_accept", 64'(n < LIM), 64'd1);
    @(negedge clk);
    s_axi_arvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] strb, input logic last);
    int n = 0;
    s_axi_wdata = d; s_axi_wstrb = strb; s_axi_wlast = last; s_axi_wvalid = 1'b1;
    while (s_axi_wready !== 1'b1 && n < LIM) begin @(negedge clk); n++; end
    check("w_accept", 64'(n < LIM), 64'd1);
    @(negedge clk);
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
  endtask

  task automatic get_b(output logic [1:0] resp);
    int n = 0;
    s_axi_bready = 1'b1;
    while (s_axi_bvalid !== 1'b1 && n < LIM) begin @(negedge clk); n++; end
    check("b_arrive", 64'(n < LIM), 64'd1);
    resp = s_axi_bresp;
    @(negedge clk);
    s_axi_bready = 1'b0;
  endtask

  task automatic get_r(output logic [31:0] d, output logic [1:0] resp, output logic last);
    int n = 0;
    s_axi_rready = 1'b1;
    while (s_axi_rvalid !== 1'b1 && n < LIM) begin @(negedge clk); n++; end
    check("r_arrive", 64'(n < LIM), 64'd1);
    d = s_axi_rdata; resp = s_axi_rresp; last = s_axi_rlast;
    @(negedge clk);
    s_axi_rready = 1'b0;
  endtask

  task automatic write1(input logic [31:0] a, input logic [31:0] d, input logic [3:0] strb,
                        output logic [1:0] resp);
    send_aw(a, 8'd0, INCR, 3'd2);
    send_w(d, strb, 1'b1);
    get_b(resp);
  endtask

  task automatic read1(input logic [31:0] a, input logic [2:0] size, input logic [1:0] burst,
                       output logic [31:0] d, output logic [1:0] resp, output logic last);
    send_ar(a, 8'd0, burst, size);
    get_r(d, resp, last);
  endtask

  // Hard stop in case the stimulus itself wedges.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, cap_d;
    logic [1:0]  r, cap_br, cap_rr;
    logic        l, cap_l, b_ok, r_ok, seen;
    logic [31:0] burst_data [4];
    int          n;
    burst_data = '{32'h11, 32'h22, 32'h33, 32'h44};

    // ---- reset values ----
    repeat (3) @(negedge clk);
    check("rst_awready", s_axi_awready, 1);
    check("rst_arready", s_axi_arready, 1);
    check("rst_wready",  s_axi_wready, 0);
    check("rst_bvalid",  s_axi_bvalid, 0);
    check("rst_bresp",   s_axi_bresp, 0);
    check("rst_rvalid",  s_axi_rvalid, 0);
    check("rst_rlast",   s_axi_rlast, 0);
    check("rst_rresp",   s_axi_rresp, 0);
    check("rst_rdata",   s_axi_rdata, 0);
    rst = 1'b0;
    @(negedge clk);

    // ---- 4-beat INCR write then read at 0x100 ----
    send_aw(32'h100, 8'd3, INCR, 3'd2);
    for (int i = 0; i < 4; i++) send_w(burst_data[i], 4'hF, i == 3);
    get_b(r);
    check("t1_bresp", r, OKAY);
    send_ar(32'h100, 8'd3, INCR, 3'd2);
    check("t1_fetch_cycle_no_rvalid", s_axi_rvalid, 0);
    @(negedge clk);
    check("t1_rvalid_two_after_ar", s_axi_rvalid, 1);
    for (int i = 0; i < 4; i++) begin
      get_r(d, r, l);
      check($sformatf("t1_rdata%0d", i), d, burst_data[i]);
      check($sformatf("t1_rresp%0d", i), r, OKAY);
      check($sformatf("t1_rlast%0d", i), l, (i == 3));
    end

    // ---- out-of-range burst at 0xFF8 leaves prior contents ----
    write1(32'hFF8, 32'hCAFE_F00D, 4'hF, r);
    check("t2_seed_bresp", r, OKAY);
    send_aw(32'hFF8, 8'd3, INCR, 3'd2);
    for (int i = 0; i < 4; i++) send_w(32'hDEAD_0000 + i, 4'hF, i == 3);
    get_b(r);
    // Beats cover words 1022..1025; words past 1023 do not exist, which
    // outranks the 4 KB crossing.
    check("t2_bresp", r, DECERR);
    read1(32'hFF8, 3'd2, INCR, d, r, l);
    check("t2_rdata_kept", d, 32'hCAFE_F00D);
    check("t2_rresp", r, OKAY);

    // ---- request-check error paths ----
    write1(32'h102, 32'hBAD0_BAD0, 4'hF, r);
    check("t3_misaligned_bresp", r, SLVERR);
    read1(32'h100, 3'd2, INCR, d, r, l);
    check("t3_no_write_on_err", d, 32'h11);
    read1(32'h1000, 3'd2, INCR, d, r, l);
    check("t3_decerr_rdata", d, 0);
    check("t3_decerr_rresp", r, DECERR);
    check("t3_decerr_rlast", l, 1);
    read1(32'h104, 3'd1, INCR, d, r, l);
    check("t3_badsize_rresp", r, SLVERR);
    check("t3_badsize_rdata", d, 0);
    send_ar(32'h100, 8'd3, WRAP, 3'd2);
    for (int i = 0; i < 4; i++) begin
      get_r(d, r, l);
      check($sformatf("t3_wrap_rdata%0d", i), d, 0);
      check($sformatf("t3_wrap_rresp%0d", i), r, SLVERR);
      check($sformatf("t3_wrap_rlast%0d", i), l, (i == 3));
    end
    send_aw(32'h300, 8'd1, FIXED, 3'd2);
    send_w(32'hA1A1_A1A1, 4'hF, 1'b0);
    send_w(32'hB2B2_B2B2, 4'hF, 1'b1);
    get_b(r);
    check("t3_fixed_bresp", r, OKAY);
    read1(32'h300, 3'd2, INCR, d, r, l);
    check("t3_fixed_rdata", d, 32'hB2B2_B2B2);

    // ---- wlast / len disagreement ----
    send_aw(32'h400, 8'd3, INCR, 3'd2);
    send_w(32'h5555_0000, 4'hF, 1'b0);
    send_w(32'h5555_1111, 4'hF, 1'b1);
    get_b(r);
    check("t4_early_wlast_bresp", r, SLVERR);
    check("t4_back_idle_awready", s_axi_awready, 1);
    check("t4_back_idle_wready", s_axi_wready, 0);
    read1(32'h400, 3'd2, INCR, d, r, l);
    check("t4_beat0_written", d, 32'h5555_0000);
    send_aw(32'h408, 8'd0, INCR, 3'd2);
    send_w(32'h99, 4'hF, 1'b0);
    get_b(r);
    check("t4_missing_wlast_bresp", r, SLVERR);
    write1(32'h180, 32'h77, 4'hF, r);
    check("t4_next_aw_bresp", r, OKAY);
    read1(32'h180, 3'd2, INCR, d, r, l);
    check("t4_next_aw_rdata", d, 32'h77);

    // ---- byte strobes and read-before-write collision at 0x200 ----
    write1(32'h200, 32'hFFFF_FFFF, 4'hF, r);
    write1(32'h200, 32'h1234_5678, 4'b0101, r);
    check("t5_strb_bresp", r, OKAY);
    read1(32'h200, 3'd2, INCR, d, r, l);
    check("t5_strb_rdata", d, 32'hFF34_FF78);
    send_aw(32'h200, 8'd0, INCR, 3'd2);
    send_ar(32'h200, 8'd0, INCR, 3'd2);
    // Read FSM is fetching now; the write beat commits on that same edge.
    s_axi_wdata = 32'hAAAA_AAAA; s_axi_wstrb = 4'hF; s_axi_wlast = 1'b1; s_axi_wvalid = 1'b1;
    check("t5_collide_wready", s_axi_wready, 1);
    check("t5_collide_fetching", s_axi_rvalid, 0);
    @(negedge clk);
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    get_r(d, r, l);
    check("t5_collide_old_data", d, 32'hFF34_FF78);
    get_b(r);
    check("t5_collide_bresp", r, OKAY);
    read1(32'h200, 3'd2, INCR, d, r, l);
    check("t5_collide_write_landed", d, 32'hAAAA_AAAA);

    // ---- B and R held under backpressure ----
    send_aw(32'h280, 8'd0, INCR, 3'd2);
    send_w(32'h1357_9BDF, 4'hF, 1'b1);
    send_ar(32'h180, 8'd0, INCR, 3'd2);
    n = 0;
    while (!(s_axi_rvalid === 1'b1 && s_axi_bvalid === 1'b1) && n < LIM) begin
      @(negedge clk); n++;
    end
    check("t6_both_valid", 64'(n < LIM), 64'd1);
    cap_br = s_axi_bresp; cap_d = s_axi_rdata; cap_rr = s_axi_rresp; cap_l = s_axi_rlast;
    b_ok = 1'b1; r_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== cap_br) b_ok = 1'b0;
      if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== cap_d ||
          s_axi_rresp !== cap_rr || s_axi_rlast !== cap_l) r_ok = 1'b0;
    end
    check("t6_b_stable", b_ok, 1);
    check("t6_r_stable", r_ok, 1);
    check("t6_held_rdata", cap_d, 32'h77);
    check("t6_held_bresp", cap_br, OKAY);
    check("t6_held_rlast", cap_l, 1);
    get_b(r);
    get_r(d, r, l);

    // ---- reset in the middle of a read burst ----
    send_ar(32'h100, 8'd3, INCR, 3'd2);
    get_r(d, r, l);
    check("t7_beat0", d, 32'h11);
    n = 0;
    while (s_axi_rvalid !== 1'b1 && n < LIM) begin @(negedge clk); n++; end
    check("t7_beat1_pending", 64'(n < LIM), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("t7_rvalid_dropped", s_axi_rvalid, 0);
    check("t7_rlast_dropped", s_axi_rlast, 0);
    rst = 1'b0;
    s_axi_rready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (s_axi_rvalid !== 1'b0) seen = 1'b1;
    end
    s_axi_rready = 1'b0;
    check("t7_no_resumed_beats", seen, 0);
    check("t7_arready_after", s_axi_arready, 1);
    check("t7_awready_after", s_axi_awready, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
